mem_port_arb: RTL and testbench

- Two-requester arbiter for the SISC single shared memory port.
- Requester A is instruction fetch (read only). Requester B is load/store data (read or write).
- Drives the select line of the 32-bit address/data mux in front of memory (sel=1 passes A, sel=0 passes B).
- Sequences each transfer with a req/ack handshake to memory, uses round-robin fairness, and has a timeout watchdog.

---
 rtl/mem_port_arb_if.sv | 27 ++
 rtl/mem_port_arb.sv | 126 ++++++++++++
 tb/tb_mem_port_arb.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arb_if.sv
// Handshake and bus-control bundle between requesters, arbiter and memory.
interface mem_port_arb_if;
   logic req_a;
   logic req_b;
   logic we_b;
   logic mem_ack;
   logic sel;
   logic mem_req;
   logic mem_we;
   logic gnt_a;
   logic gnt_b;
   logic done_a;
   logic done_b;
   logic tmo_err;

   // Arbiter side
   modport slave (
      input  req_a, req_b, we_b, mem_ack,
      output sel, mem_req, mem_we, gnt_a, gnt_b, done_a, done_b, tmo_err
   );

   // Requester / memory side
   modport master (
      output req_a, req_b, we_b, mem_ack,
      input  sel, mem_req, mem_we, gnt_a, gnt_b, done_a, done_b, tmo_err
   );
endinterface

// File: rtl/mem_port_arb.sv
// Round-robin arbiter for the single shared memory port: fetch (A) vs load/store (B),
// req/ack sequencing toward memory and a per-transfer timeout watchdog.
module mem_port_arb #(
   parameter int unsigned TMO_CYC = 16,
   parameter int unsigned CNT_W   = 5
) (
   input  logic              clk,
   input  logic              rst_f,
   mem_port_arb_if.slave     bus
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] XFER_A = 2'd1;
   localparam logic [1:0] XFER_B = 2'd2;

   localparam logic LAST_A = 1'b1;
   localparam logic LAST_B = 1'b0;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_CYC - 1);

   logic [1:0]       state_q,   state_nxt;
   logic             sel_q,     sel_nxt;
   logic             req_q,     req_nxt;
   logic             we_q,      we_nxt;
   logic             gnt_a_q,   gnt_a_nxt;
   logic             gnt_b_q,   gnt_b_nxt;
   logic             tmo_q,     tmo_nxt;
   logic [CNT_W-1:0] cnt_q,     cnt_nxt;
   logic             last_q,    last_nxt;

   // State and registered-output flops
   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         state_q <= IDLE;
         sel_q   <= 1'b1;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
         tmo_q   <= 1'b0;
         cnt_q   <= '0;
         last_q  <= LAST_B;
      end else begin
         state_q <= state_nxt;
         sel_q   <= sel_nxt;
         req_q   <= req_nxt;
         we_q    <= we_nxt;
         gnt_a_q <= gnt_a_nxt;
         gnt_b_q <= gnt_b_nxt;
         tmo_q   <= tmo_nxt;
         cnt_q   <= cnt_nxt;
         last_q  <= last_nxt;
      end
   end

   // Next-state: grant selection in IDLE, completion / watchdog in XFER
   always_comb begin
      state_nxt = state_q;
      sel_nxt   = sel_q;
      req_nxt   = req_q;
      we_nxt    = we_q;
      gnt_a_nxt = gnt_a_q;
      gnt_b_nxt = gnt_b_q;
      tmo_nxt   = tmo_q;
      cnt_nxt   = cnt_q;
      last_nxt  = last_q;

      case (state_q)
         IDLE: begin
            // On contention the port that did not go last wins
            if (bus.req_a && (!bus.req_b || (last_q == LAST_B))) begin
               state_nxt = XFER_A;
               sel_nxt   = 1'b1;
               gnt_a_nxt = 1'b1;
               req_nxt   = 1'b1;
               we_nxt    = 1'b0;
               cnt_nxt   = '0;
            end else if (bus.req_b) begin
               state_nxt = XFER_B;
               sel_nxt   = 1'b0;
               gnt_b_nxt = 1'b1;
               req_nxt   = 1'b1;
               we_nxt    = bus.we_b;
               cnt_nxt   = '0;
            end
         end

         XFER_A, XFER_B: begin
            // Ack wins over a coincident timeout
            if (bus.mem_ack || (cnt_q == CNT_LAST)) begin
               state_nxt = IDLE;
               req_nxt   = 1'b0;
               we_nxt    = 1'b0;
               gnt_a_nxt = 1'b0;
               gnt_b_nxt = 1'b0;
               last_nxt  = (state_q == XFER_A) ? LAST_A : LAST_B;
               if (!bus.mem_ack) begin
                  tmo_nxt = 1'b1;
               end
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end

         default: begin
            state_nxt = IDLE;
            req_nxt   = 1'b0;
            we_nxt    = 1'b0;
            gnt_a_nxt = 1'b0;
            gnt_b_nxt = 1'b0;
         end
      endcase
   end

   assign bus.sel     = sel_q;
   assign bus.mem_req = req_q;
   assign bus.mem_we  = we_q;
   assign bus.gnt_a   = gnt_a_q;
   assign bus.gnt_b   = gnt_b_q;
   assign bus.tmo_err = tmo_q;

   // Completion pulses follow memory ack within the same cycle
   assign bus.done_a  = gnt_a_q & bus.mem_ack;
   assign bus.done_b  = gnt_b_q & bus.mem_ack;

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: scenario tasks plus a grant scoreboard.
module tb_mem_port_arb;

   localparam int unsigned TMO = 16;

   logic clk;
   logic rst_f;

   mem_port_arb_if bus();

   mem_port_arb #(.TMO_CYC(TMO), .CNT_W(5)) dut (
      .clk   (clk),
      .rst_f (rst_f),
      .bus   (bus)
   );

   typedef struct {
      logic port_a;
      logic we;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [3:0] mon_obs;
   logic [3:0] mon_want;
   logic       prev_req;
   int         n_cmp;
   int         n_err;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every new transfer toward memory must match the oldest expected grant
   always @(negedge clk) begin
      if (!rst_f) begin
         prev_req = 1'b0;
      end else begin
         if (bus.mem_req && !prev_req) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL sb_unexpected_grant: got gnt_a=%b gnt_b=%b, required no grant", bus.gnt_a, bus.gnt_b);
            end else begin
               mon_e    = exp_q.pop_front();
               mon_obs  = {bus.gnt_a, bus.gnt_b, bus.sel, bus.mem_we};
               mon_want = {mon_e.port_a, ~mon_e.port_a, mon_e.port_a, mon_e.we};
               if (mon_obs !== mon_want) begin
                  n_err++;
                  $display("FAIL sb_grant {gnt_a,gnt_b,sel,we}: got %b required %b", mon_obs, mon_want);
               end
            end
         end
         prev_req = bus.mem_req;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, required finish");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_f = 1'b0;
      bus.mem_ack = 1'b1;
      repeat (2) cyc();
      n_cmp++;
      if ({bus.sel, bus.mem_req, bus.mem_we, bus.gnt_a, bus.gnt_b, bus.tmo_err} !== 6'b100000) begin
         n_err++;
         $display("FAIL reset_outputs: got %b required 100000",
                  {bus.sel, bus.mem_req, bus.mem_we, bus.gnt_a, bus.gnt_b, bus.tmo_err});
      end
      n_cmp++;
      if ({bus.done_a, bus.done_b} !== 2'b00) begin
         n_err++;
         $display("FAIL reset_done: got %b required 00", {bus.done_a, bus.done_b});
      end
      bus.mem_ack = 1'b0;
      rst_f = 1'b1;
      cyc();
      n_cmp++;
      if ({bus.sel, bus.mem_req, bus.gnt_a, bus.gnt_b} !== 4'b1000) begin
         n_err++;
         $display("FAIL reset_idle_hold: got %b required 1000", {bus.sel, bus.mem_req, bus.gnt_a, bus.gnt_b});
      end
   endtask

   task automatic test_fetch();
      bus.req_a = 1'b1;
      exp_q.push_back('{port_a: 1'b1, we: 1'b0});
      cyc();
      n_cmp++;
      if ({bus.sel, bus.mem_req, bus.mem_we, bus.gnt_a, bus.gnt_b, bus.done_a} !== 6'b110100) begin
         n_err++;
         $display("FAIL fetch_cycle1: got %b required 110100",
                  {bus.sel, bus.mem_req, bus.mem_we, bus.gnt_a, bus.gnt_b, bus.done_a});
      end
      cyc();
      bus.mem_ack = 1'b1;
      #1;
      n_cmp++;
      if ({bus.mem_req, bus.done_a, bus.done_b} !== 3'b110) begin
         n_err++;
         $display("FAIL fetch_cycle2_done: got %b required 110", {bus.mem_req, bus.done_a, bus.done_b});
      end
      bus.req_a = 1'b0;
      cyc();
      bus.mem_ack = 1'b0;
      #1;
      n_cmp++;
      if ({bus.sel, bus.mem_req, bus.mem_we, bus.gnt_a, bus.done_a} !== 5'b10000) begin
         n_err++;
         $display("FAIL fetch_idle: got %b required 10000",
                  {bus.sel, bus.mem_req, bus.mem_we, bus.gnt_a, bus.done_a});
      end
   endtask

   task automatic test_write();
      bus.req_b = 1'b1;
      bus.we_b  = 1'b1;
      exp_q.push_back('{port_a: 1'b0, we: 1'b1});
      cyc();
      n_cmp++;
      if ({bus.sel, bus.mem_req, bus.mem_we, bus.gnt_a, bus.gnt_b} !== 5'b01101) begin
         n_err++;
         $display("FAIL write_grant: got %b required 01101",
                  {bus.sel, bus.mem_req, bus.mem_we, bus.gnt_a, bus.gnt_b});
      end
      bus.we_b = 1'b0;
      repeat (2) begin
         cyc();
         n_cmp++;
         if ({bus.sel, bus.mem_req, bus.mem_we, bus.gnt_b} !== 4'b0111) begin
            n_err++;
            $display("FAIL write_we_held: got %b required 0111", {bus.sel, bus.mem_req, bus.mem_we, bus.gnt_b});
         end
      end
      bus.mem_ack = 1'b1;
      #1;
      n_cmp++;
      if ({bus.done_a, bus.done_b} !== 2'b01) begin
         n_err++;
         $display("FAIL write_done: got %b required 01", {bus.done_a, bus.done_b});
      end
      bus.req_b = 1'b0;
      cyc();
      bus.mem_ack = 1'b0;
      n_cmp++;
      if ({bus.sel, bus.mem_req, bus.mem_we, bus.gnt_b} !== 4'b0000) begin
         n_err++;
         $display("FAIL write_idle_sel_hold: got %b required 0000", {bus.sel, bus.mem_req, bus.mem_we, bus.gnt_b});
      end
   endtask

   task automatic test_round_robin();
      logic want_a;
      for (int t = 0; t < 4; t++) begin
         exp_q.push_back('{port_a: (t % 2 == 0), we: 1'b0});
      end
      bus.req_a   = 1'b1;
      bus.req_b   = 1'b1;
      bus.we_b    = 1'b0;
      bus.mem_ack = 1'b1;
      for (int t = 0; t < 4; t++) begin
         want_a = (t % 2 == 0);
         cyc();
         n_cmp++;
         if ({bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b} !== {want_a, ~want_a, want_a, ~want_a}) begin
            n_err++;
            $display("FAIL rr_xfer%0d {gnt_a,gnt_b,done_a,done_b}: got %b required %b", t,
                     {bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b}, {want_a, ~want_a, want_a, ~want_a});
         end
         if (t == 3) begin
            bus.req_a = 1'b0;
            bus.req_b = 1'b0;
         end
         cyc();
         n_cmp++;
         if ({bus.mem_req, bus.done_a, bus.done_b} !== 3'b000) begin
            n_err++;
            $display("FAIL rr_idle%0d: got %b required 000", t, {bus.mem_req, bus.done_a, bus.done_b});
         end
      end
      bus.mem_ack = 1'b0;
   endtask

   task automatic test_last_a();
      bus.req_a   = 1'b1;
      bus.mem_ack = 1'b1;
      exp_q.push_back('{port_a: 1'b1, we: 1'b0});
      cyc();
      bus.req_a = 1'b0;
      cyc();
      bus.mem_ack = 1'b0;
      bus.req_a   = 1'b1;
      bus.req_b   = 1'b1;
      exp_q.push_back('{port_a: 1'b0, we: 1'b0});
      exp_q.push_back('{port_a: 1'b1, we: 1'b0});
      cyc();
      n_cmp++;
      if ({bus.gnt_a, bus.gnt_b} !== 2'b01) begin
         n_err++;
         $display("FAIL last_a_b_first: got %b required 01", {bus.gnt_a, bus.gnt_b});
      end
      bus.mem_ack = 1'b1;
      bus.req_b   = 1'b0;
      cyc();
      cyc();
      n_cmp++;
      if ({bus.gnt_a, bus.gnt_b, bus.done_a} !== 3'b101) begin
         n_err++;
         $display("FAIL last_a_then_a: got %b required 101", {bus.gnt_a, bus.gnt_b, bus.done_a});
      end
      bus.req_a = 1'b0;
      cyc();
      bus.mem_ack = 1'b0;
   endtask

   task automatic test_ack_at_limit();
      int dones;
      dones = 0;
      bus.req_a = 1'b1;
      exp_q.push_back('{port_a: 1'b1, we: 1'b0});
      cyc();
      for (int i = 1; i < int'(TMO); i++) begin
         if (bus.done_a) dones++;
         cyc();
      end
      n_cmp++;
      if ({bus.mem_req, bus.gnt_a, dones[0]} !== 3'b110 || dones != 0) begin
         n_err++;
         $display("FAIL limit_still_busy: got req=%b gnt_a=%b dones=%0d required 1 1 0", bus.mem_req, bus.gnt_a, dones);
      end
      bus.mem_ack = 1'b1;
      #1;
      n_cmp++;
      if (bus.done_a !== 1'b1) begin
         n_err++;
         $display("FAIL limit_done: got %b required 1", bus.done_a);
      end
      bus.req_a = 1'b0;
      cyc();
      bus.mem_ack = 1'b0;
      n_cmp++;
      if ({bus.mem_req, bus.gnt_a, bus.tmo_err} !== 3'b000) begin
         n_err++;
         $display("FAIL limit_no_err: got %b required 000", {bus.mem_req, bus.gnt_a, bus.tmo_err});
      end
   endtask

   task automatic test_timeout();
      int dones;
      int busy;
      dones = 0;
      busy  = 0;
      bus.req_a = 1'b1;
      exp_q.push_back('{port_a: 1'b1, we: 1'b0});
      cyc();
      for (int i = 0; i < int'(TMO); i++) begin
         if (bus.mem_req && bus.gnt_a && !bus.tmo_err) busy++;
         if (bus.done_a) dones++;
         cyc();
      end
      n_cmp++;
      if (busy != int'(TMO) || dones != 0) begin
         n_err++;
         $display("FAIL tmo_window: got busy=%0d dones=%0d required busy=%0d dones=0", busy, dones, TMO);
      end
      n_cmp++;
      if ({bus.mem_req, bus.gnt_a, bus.tmo_err} !== 3'b001) begin
         n_err++;
         $display("FAIL tmo_abort: got %b required 001", {bus.mem_req, bus.gnt_a, bus.tmo_err});
      end
      exp_q.push_back('{port_a: 1'b1, we: 1'b0});
      cyc();
      n_cmp++;
      if ({bus.mem_req, bus.gnt_a, bus.tmo_err} !== 3'b111) begin
         n_err++;
         $display("FAIL tmo_retry: got %b required 111", {bus.mem_req, bus.gnt_a, bus.tmo_err});
      end
      bus.mem_ack = 1'b1;
      bus.req_a   = 1'b0;
      cyc();
      bus.mem_ack = 1'b0;
      cyc();
      n_cmp++;
      if ({bus.mem_req, bus.tmo_err} !== 2'b01) begin
         n_err++;
         $display("FAIL tmo_sticky: got %b required 01", {bus.mem_req, bus.tmo_err});
      end
   endtask

   task automatic test_reset_mid();
      bus.req_b = 1'b1;
      bus.we_b  = 1'b1;
      exp_q.push_back('{port_a: 1'b0, we: 1'b1});
      cyc();
      bus.mem_ack = 1'b1;
      #2;
      rst_f = 1'b0;
      #1;
      n_cmp++;
      if ({bus.sel, bus.mem_req, bus.mem_we, bus.gnt_a, bus.gnt_b, bus.tmo_err, bus.done_b} !== 7'b1000000) begin
         n_err++;
         $display("FAIL reset_mid_xfer: got %b required 1000000",
                  {bus.sel, bus.mem_req, bus.mem_we, bus.gnt_a, bus.gnt_b, bus.tmo_err, bus.done_b});
      end
      bus.req_b   = 1'b0;
      bus.we_b    = 1'b0;
      bus.mem_ack = 1'b0;
      @(negedge clk);
      rst_f = 1'b1;
      cyc();
   endtask

   task automatic test_stray_ack();
      bus.mem_ack = 1'b1;
      #1;
      n_cmp++;
      if ({bus.done_a, bus.done_b} !== 2'b00) begin
         n_err++;
         $display("FAIL stray_ack_done: got %b required 00", {bus.done_a, bus.done_b});
      end
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_cmp++;
         if ({bus.sel, bus.mem_req, bus.mem_we, bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b} !== 7'b1000000) begin
            n_err++;
            $display("FAIL stray_ack_idle%0d: got %b required 1000000", i,
                     {bus.sel, bus.mem_req, bus.mem_we, bus.gnt_a, bus.gnt_b, bus.done_a, bus.done_b});
         end
      end
      bus.mem_ack = 1'b0;
   endtask

   initial begin
      n_cmp       = 0;
      n_err       = 0;
      prev_req    = 1'b0;
      rst_f       = 1'b0;
      bus.req_a   = 1'b0;
      bus.req_b   = 1'b0;
      bus.we_b    = 1'b0;
      bus.mem_ack = 1'b0;

      test_reset();
      test_fetch();
      test_write();
      test_round_robin();
      test_last_a();
      test_ack_at_limit();
      test_timeout();
      test_reset_mid();
      test_stray_ack();

      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL sb_leftover: got %0d pending grants required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
